// File: rtl/axi_log_arbiter.sv
// axi_log_arbiter
//   Merges the AR and AW handshake events of one AXI port into the single
//   event stream consumed by the AXI BRAM logger. Each channel queues events
//   in a small FIFO; a round-robin scheduler emits at most one event per
//   cycle and tags the ID MSB with the source channel (0 = AR, 1 = AW).
//
// Ports
//   Clk_CI, Rst_RBI                     clock, synchronous active-low reset
//   Ar*/Aw* (Valid, Ready, Id, Addr, Len) monitored AXI address channels
//   Enable_SI                           capture enable
//   Clear_SI                            flush FIFOs, counters and RR pointer
//   LogStall_SI                         logger full/clearing, blocks pops
//   LogValid_SO, LogId_DO,
//   LogAddr_DO, LogLen_DO               registered event output
//   ArDropCnt_DO, AwDropCnt_DO          saturating overflow-drop counters
module axi_log_arbiter #(
  parameter int unsigned AXI_ID_BITW   = 8,
  parameter int unsigned AXI_ADDR_BITW = 32,
  parameter int unsigned AXI_LEN_BITW  = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DROP_CNT_BITW = 16
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RBI,
  input  logic                     ArValid_SI,
  input  logic                     ArReady_SI,
  input  logic [AXI_ID_BITW-1:0]   ArId_DI,
  input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
  input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
  input  logic                     AwValid_SI,
  input  logic                     AwReady_SI,
  input  logic [AXI_ID_BITW-1:0]   AwId_DI,
  input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
  input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
  input  logic                     Enable_SI,
  input  logic                     Clear_SI,
  input  logic                     LogStall_SI,
  output logic                     LogValid_SO,
  output logic [AXI_ID_BITW:0]     LogId_DO,
  output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
  output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
  output logic [DROP_CNT_BITW-1:0] ArDropCnt_DO,
  output logic [DROP_CNT_BITW-1:0] AwDropCnt_DO
);

  localparam int unsigned IDX_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W   = IDX_W + 1;
  localparam int unsigned ENTRY_W = AXI_ID_BITW + AXI_ADDR_BITW + AXI_LEN_BITW;

  // Index 0 = AR channel, index 1 = AW channel throughout.
  logic [ENTRY_W-1:0]       mem_q      [2][FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q   [2];
  logic [PTR_W-1:0]         rd_ptr_q   [2];
  logic [DROP_CNT_BITW-1:0] drop_cnt_q [2];
  logic                     rr_q;

  logic [ENTRY_W-1:0] entry_in [2];
  logic [1:0]         push_req;
  logic [1:0]         empty;
  logic [1:0]         full;
  logic [1:0]         pop;
  logic [1:0]         push_ok;
  logic [1:0]         drop;
  logic               contested;
  logic               sel;
  logic [ENTRY_W-1:0] head;

  always_comb begin
    entry_in[0] = {ArId_DI, ArAddr_DI, ArLen_DI};
    entry_in[1] = {AwId_DI, AwAddr_DI, AwLen_DI};
    push_req[0] = ArValid_SI & ArReady_SI & Enable_SI & ~Clear_SI;
    push_req[1] = AwValid_SI & AwReady_SI & Enable_SI & ~Clear_SI;

    for (int unsigned c = 0; c < 2; c++) begin
      empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
      // Full when the index bits match but the wrap bits differ.
      full[c]  = (wr_ptr_q[c][PTR_W-1] != rd_ptr_q[c][PTR_W-1]) &&
                 (wr_ptr_q[c][IDX_W-1:0] == rd_ptr_q[c][IDX_W-1:0]);
    end

    pop       = 2'b00;
    contested = 1'b0;
    if (!LogStall_SI && !Clear_SI) begin
      if (!empty[0] && !empty[1]) begin
        pop[rr_q] = 1'b1;
        contested = 1'b1;
      end else if (!empty[0]) begin
        pop[0] = 1'b1;
      end else if (!empty[1]) begin
        pop[1] = 1'b1;
      end
    end

    // A full FIFO still accepts a push when it is popped in the same cycle.
    for (int unsigned c = 0; c < 2; c++) begin
      push_ok[c] = push_req[c] & (~full[c] | pop[c]);
      drop[c]    = push_req[c] & full[c] & ~pop[c];
    end

    sel  = pop[1];
    head = mem_q[sel][rd_ptr_q[sel][IDX_W-1:0]];
  end

  always_ff @(posedge Clk_CI) begin
    for (int unsigned c = 0; c < 2; c++) begin
      if (push_ok[c]) begin
        mem_q[c][wr_ptr_q[c][IDX_W-1:0]] <= entry_in[c];
      end
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      for (int unsigned c = 0; c < 2; c++) begin
        wr_ptr_q[c]   <= '0;
        rd_ptr_q[c]   <= '0;
        drop_cnt_q[c] <= '0;
      end
      rr_q        <= 1'b0;
      LogValid_SO <= 1'b0;
      LogId_DO    <= '0;
      LogAddr_DO  <= '0;
      LogLen_DO   <= '0;
    end else if (Clear_SI) begin
      for (int unsigned c = 0; c < 2; c++) begin
        wr_ptr_q[c]   <= '0;
        rd_ptr_q[c]   <= '0;
        drop_cnt_q[c] <= '0;
      end
      rr_q        <= 1'b0;
      LogValid_SO <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        if (push_ok[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        if (pop[c])     rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        if (drop[c] && (drop_cnt_q[c] != '1)) begin
          drop_cnt_q[c] <= drop_cnt_q[c] + 1'b1;
        end
      end
      // Pointer only moves when both channels competed for the slot.
      if (contested) rr_q <= ~rr_q;
      LogValid_SO <= |pop;
      if (|pop) begin
        {LogId_DO, LogAddr_DO, LogLen_DO} <= {sel, head};
      end
    end
  end

  assign ArDropCnt_DO = drop_cnt_q[0];
  assign AwDropCnt_DO = drop_cnt_q[1];

endmodule

// File: tb/tb_axi_log_arbiter.sv
module tb_axi_log_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ar_valid, ar_ready, aw_valid, aw_ready;
  logic [7:0]  ar_id, aw_id, ar_len, aw_len;
  logic [31:0] ar_addr, aw_addr;
  logic        enable, clear, stall;

  logic        v4, v8;
  logic [8:0]  id4, id8;
  logic [31:0] addr4, addr8;
  logic [7:0]  len4, len8;
  logic [1:0]  ardrop4, awdrop4;
  logic [15:0] ardrop8, awdrop8;

  int tot = 0;
  int bad = 0;
  bit en4 = 1'b0;
  bit en8 = 1'b0;
  logic [48:0] q4[$];
  logic [48:0] q8[$];

  always #5 clk = ~clk;

  // Main instance: depth 4 with a 2-bit drop counter for overflow/saturation cases.
  axi_log_arbiter #(
    .AXI_ID_BITW(8), .AXI_ADDR_BITW(32), .AXI_LEN_BITW(8),
    .FIFO_DEPTH(4), .DROP_CNT_BITW(2)
  ) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .ArValid_SI(ar_valid), .ArReady_SI(ar_ready), .ArId_DI(ar_id),
    .ArAddr_DI(ar_addr), .ArLen_DI(ar_len),
    .AwValid_SI(aw_valid), .AwReady_SI(aw_ready), .AwId_DI(aw_id),
    .AwAddr_DI(aw_addr), .AwLen_DI(aw_len),
    .Enable_SI(enable), .Clear_SI(clear), .LogStall_SI(stall),
    .LogValid_SO(v4), .LogId_DO(id4), .LogAddr_DO(addr4), .LogLen_DO(len4),
    .ArDropCnt_DO(ardrop4), .AwDropCnt_DO(awdrop4)
  );

  // Depth-8 instance: an 8-cycle dual-channel burst backlogs 4 entries per
  // channel by cycle 7, so a lossless burst needs more than 4 entries.
  axi_log_arbiter #(
    .AXI_ID_BITW(8), .AXI_ADDR_BITW(32), .AXI_LEN_BITW(8),
    .FIFO_DEPTH(8), .DROP_CNT_BITW(16)
  ) dut8 (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .ArValid_SI(ar_valid), .ArReady_SI(ar_ready), .ArId_DI(ar_id),
    .ArAddr_DI(ar_addr), .ArLen_DI(ar_len),
    .AwValid_SI(aw_valid), .AwReady_SI(aw_ready), .AwId_DI(aw_id),
    .AwAddr_DI(aw_addr), .AwLen_DI(aw_len),
    .Enable_SI(enable), .Clear_SI(clear), .LogStall_SI(stall),
    .LogValid_SO(v8), .LogId_DO(id8), .LogAddr_DO(addr8), .LogLen_DO(len8),
    .ArDropCnt_DO(ardrop8), .AwDropCnt_DO(awdrop8)
  );

  function automatic logic [48:0] ev(input logic ch, input logic [7:0] id,
                                     input logic [31:0] a, input logic [7:0] l);
    return {ch, id, a, l};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tot++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (en4 && v4 === 1'b1) begin
      tot++;
      assert (q4.size() != 0) else begin
        bad++;
        $error("FAIL ev4_unexpected got=%0h exp=none", {id4, addr4, len4});
      end
      if (q4.size() != 0) begin
        logic [48:0] e;
        e = q4.pop_front();
        tot++;
        assert ({id4, addr4, len4} === e) else begin
          bad++;
          $error("FAIL ev4 got=%0h exp=%0h", {id4, addr4, len4}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en8 && v8 === 1'b1) begin
      tot++;
      assert (q8.size() != 0) else begin
        bad++;
        $error("FAIL ev8_unexpected got=%0h exp=none", {id8, addr8, len8});
      end
      if (q8.size() != 0) begin
        logic [48:0] e;
        e = q8.pop_front();
        tot++;
        assert ({id8, addr8, len8} === e) else begin
          bad++;
          $error("FAIL ev8 got=%0h exp=%0h", {id8, addr8, len8}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One cycle of stimulus; handshakes are sampled at the following edge.
  task automatic cyc(input logic arv, input logic [7:0] aid, input logic [31:0] aa,
                     input logic [7:0] al, input logic awv, input logic [7:0] wid,
                     input logic [31:0] wa, input logic [7:0] wl);
    ar_valid = arv; ar_id = aid; ar_addr = aa; ar_len = al;
    aw_valid = awv; aw_id = wid; aw_addr = wa; aw_len = wl;
    tick();
    ar_valid = 1'b0;
    aw_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 64) begin
      tick();
      n++;
    end
    chk(tag, q4.size() + q8.size(), 0);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; stall = 1'b0;
    ar_valid = 1'b0; ar_ready = 1'b1; ar_id = '0; ar_addr = '0; ar_len = '0;
    aw_valid = 1'b0; aw_ready = 1'b1; aw_id = '0; aw_addr = '0; aw_len = '0;
    idle(2);
    chk("rst_valid", v4, 0);
    chk("rst_data", {id4, addr4, len4}, 0);
    chk("rst_drops", {ardrop4, awdrop4}, 0);
    rst_n = 1'b1;
    tick();
    en4 = 1'b1;

    // 1: single AR event, two-cycle latency, single pulse
    q4.push_back(ev(0, 8'h12, 32'h1000, 8'd3));
    cyc(1, 8'h12, 32'h1000, 8'd3, 0, 0, 0, 0);
    chk("t1_lat_c1", v4, 0);
    tick();
    chk("t1_valid_c2", v4, 1);
    chk("t1_id", id4, 9'h012);
    chk("t1_addr", addr4, 32'h1000);
    chk("t1_len", len4, 3);
    tick();
    chk("t1_one_pulse", v4, 0);
    // valid without ready is not a handshake
    ar_ready = 1'b0;
    cyc(1, 8'h77, 32'h7777, 8'd7, 0, 0, 0, 0);
    ar_ready = 1'b1;
    idle(4);
    chk("t1_hold_addr", addr4, 32'h1000);
    drain("t1_drain");

    // 2: both channels every cycle for 8 cycles, alternating output
    en4 = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    en8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q8.push_back(ev(0, 8'(i), 32'h2000 + 32'(i * 4), 8'(i)));
      q8.push_back(ev(1, 8'(8'h80 + i), 32'h3000 + 32'(i * 16), 8'(i + 1)));
      ar_valid = 1'b1; ar_id = 8'(i); ar_addr = 32'h2000 + 32'(i * 4); ar_len = 8'(i);
      aw_valid = 1'b1; aw_id = 8'(8'h80 + i); aw_addr = 32'h3000 + 32'(i * 16);
      aw_len = 8'(i + 1);
      tick();
    end
    ar_valid = 1'b0; aw_valid = 1'b0;
    // depth-4 instance: both FIFOs full at cycle 7, AR wins the slot, AW drops once
    chk("t2_d4_awdrop", awdrop4, 1);
    chk("t2_d4_ardrop", ardrop4, 0);
    drain("t2_drain");
    chk("t2_drops8", {ardrop8, awdrop8}, 0);
    en8 = 1'b0;
    idle(20);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t2_clr_valid", v4, 0);
    chk("t2_clr_drops", {ardrop4, awdrop4}, 0);
    en4 = 1'b1;

    // 3: stall for 10 cycles with 6 AW handshakes -> 2 drops, 4 drained in order
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) q4.push_back(ev(1, 8'(8'h40 + i), 32'h4000 + 32'(i * 256), 8'(i)));
      cyc(0, 0, 0, 0, (i < 6), 8'(8'h40 + i), 32'h4000 + 32'(i * 256), 8'(i));
    end
    chk("t3_awdrop", awdrop4, 2);
    chk("t3_stalled", v4, 0);
    stall = 1'b0;
    drain("t3_drain");

    // 4: saturating drop counter (2 bits, 6 drops)
    clear = 1'b1; tick(); clear = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) q4.push_back(ev(1, 8'(8'h60 + i), 32'h6000 + 32'(i), 8'd9));
      cyc(0, 0, 0, 0, 1, 8'(8'h60 + i), 32'h6000 + 32'(i), 8'd9);
      if (i == 6) chk("t4_drop3", awdrop4, 3);
    end
    chk("t4_sat", awdrop4, 3);
    stall = 1'b0;
    drain("t4_drain");

    // 5: clear with queued entries and a same-cycle AR handshake
    clear = 1'b1; tick(); clear = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h50 + i), 32'h5000, 8'd1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 8'(8'h58 + i), 32'h5800, 8'd2);
    chk("t5_pre_drop", awdrop4, 1);
    clear = 1'b1;
    cyc(1, 8'h5F, 32'h5F00, 8'd4, 0, 0, 0, 0);
    clear = 1'b0;
    stall = 1'b0;
    chk("t5_clr_drops", {ardrop4, awdrop4}, 0);
    chk("t5_clr_valid", v4, 0);
    idle(6);
    q4.push_back(ev(0, 8'h55, 32'h5500, 8'd5));
    cyc(1, 8'h55, 32'h5500, 8'd5, 0, 0, 0, 0);
    chk("t5_lat_c1", v4, 0);
    tick();
    chk("t5_valid_c2", v4, 1);
    chk("t5_id", id4, 9'h055);
    drain("t5_drain");

    // 6: contested grant leaves pointer at AW, then reset discards queue
    stall = 1'b1;
    q4.push_back(ev(0, 8'h21, 32'h2100, 8'd1));
    q4.push_back(ev(1, 8'h31, 32'h3100, 8'd2));
    cyc(1, 8'h21, 32'h2100, 8'd1, 1, 8'h31, 32'h3100, 8'd2);
    stall = 1'b0;
    drain("t6_pre_drain");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h90 + i), 32'h9000, 8'd3, 0, 0, 0, 0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h98 + i), 32'h9800, 8'd3, 1, 8'h99, 32'h9900, 8'd3);
    chk("t6_en_low_nodrop", {ardrop4, awdrop4}, 0);
    rst_n = 1'b0;
    tick();
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    enable = 1'b1;
    chk("t6_rst_valid", v4, 0);
    chk("t6_rst_data", {id4, addr4, len4}, 0);
    chk("t6_rst_drops", {ardrop4, awdrop4}, 0);
    idle(6);
    stall = 1'b1;
    q4.push_back(ev(0, 8'h0A, 32'hA000, 8'd6));
    q4.push_back(ev(1, 8'h0B, 32'hB000, 8'd7));
    cyc(1, 8'h0A, 32'hA000, 8'd6, 1, 8'h0B, 32'hB000, 8'd7);
    stall = 1'b0;
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
